// File: rtl/sprite_layer_n_pkg.sv
// Shared VGA bus layout and coordinate helpers for the N-channel sprite compositor.
package sprite_layer_n_pkg;

  localparam int SPR_COORD_W = 12;
  localparam int SPR_RGB_W   = 12;

  typedef struct packed {
    logic [SPR_COORD_W-1:0] hcount;
    logic [SPR_COORD_W-1:0] vcount;
    logic                   hsync;
    logic                   vsync;
    logic                   hblnk;
    logic                   vblnk;
    logic [SPR_RGB_W-1:0]   rgb;
  } vga_bus_t;

  localparam int VGA_BUS_SIZE = $bits(vga_bus_t);

  // Extra MSB keeps a negative offset visible as a large value, so it never passes a box test.
  function automatic logic [SPR_COORD_W:0] coord_offset(
    input logic [SPR_COORD_W-1:0] pos,
    input logic [SPR_COORD_W-1:0] origin
  );
    return {1'b0, pos} - {1'b0, origin};
  endfunction

endpackage

// File: rtl/sprite_layer_n_sprite_channel.sv
// One sprite channel: frame-latched position, hit test, ROM address and hit delay line.
// Address is 1 pclk after the pixel, hit is 1+ROM_LAT pclk after it; free-running, no backpressure.
module sprite_layer_n_sprite_channel
  import sprite_layer_n_pkg::*;
#(
  parameter int SPR_W   = 64,
  parameter int SPR_H   = 64,
  parameter int ADDR_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [SPR_COORD_W-1:0] xpos,
  input  logic [SPR_COORD_W-1:0] ypos,
  input  logic                   en,
  input  logic [SPR_COORD_W-1:0] hcount,
  input  logic [SPR_COORD_W-1:0] vcount,
  input  logic                   hblnk,
  input  logic                   vblnk,
  output logic [ADDR_W-1:0]      pixel_addr,
  output logic                   hit
);

  localparam logic [SPR_COORD_W:0] W_LIM = (SPR_COORD_W+1)'(SPR_W);
  localparam logic [SPR_COORD_W:0] H_LIM = (SPR_COORD_W+1)'(SPR_H);

  logic [SPR_COORD_W-1:0] sx;
  logic [SPR_COORD_W-1:0] sy;
  logic                   sen;
  logic [SPR_COORD_W:0]   dx;
  logic [SPR_COORD_W:0]   dy;
  logic                   in_box;
  logic [ADDR_W-1:0]      lin_addr;
  logic [ROM_LAT:0]       hit_pipe;

  // Positions only move at the start of vertical blanking so a frame never tears.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      sx  <= '0;
      sy  <= '0;
      sen <= 1'b0;
    end else if (frame_start) begin
      sx  <= xpos;
      sy  <= ypos;
      sen <= en;
    end
  end

  assign dx     = coord_offset(hcount, sx);
  assign dy     = coord_offset(vcount, sy);
  assign in_box = sen & ~hblnk & ~vblnk & (dx < W_LIM) & (dy < H_LIM);

  // Modular arithmetic in ADDR_W bits gives the same result as truncating the full product.
  assign lin_addr = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pixel_addr <= '0;
      hit_pipe   <= '0;
    end else begin
      pixel_addr <= in_box ? lin_addr : '0;
      hit_pipe   <= {hit_pipe[ROM_LAT-1:0], in_box};
    end
  end

  assign hit = hit_pipe[ROM_LAT];

endmodule

// File: rtl/sprite_layer_n.sv
// N-channel sprite compositor on the VGA bus, channel 0 on top; latency ROM_LAT+2 pclk, no backpressure.
// SPRITE_COLLISION_EN adds per-frame collision flags; without it coll_flags is tied low.
module sprite_layer_n
  import sprite_layer_n_pkg::*;
#(
  parameter int                   N       = 2,
  parameter int                   SPR_W   = 64,
  parameter int                   SPR_H   = 64,
  parameter int                   ADDR_W  = 12,
  parameter int                   ROM_LAT = 1,
  parameter logic [SPR_RGB_W-1:0] KEY_RGB = 12'hF0F
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [VGA_BUS_SIZE-1:0]    vga_in,
  input  logic [N*SPR_COORD_W-1:0]   xpos,
  input  logic [N*SPR_COORD_W-1:0]   ypos,
  input  logic [N-1:0]               spr_en,
  output logic [N*ADDR_W-1:0]        pixel_addr,
  input  logic [N*SPR_RGB_W-1:0]     rom_data,
  output logic [VGA_BUS_SIZE-1:0]    vga_out,
  output logic [N-1:0]               coll_flags,
  output logic                       frame_tick
);

  vga_bus_t             bus_in;
  vga_bus_t             bus_pipe [ROM_LAT+1];
  vga_bus_t             bus_al;
  vga_bus_t             bus_mix;
  vga_bus_t             bus_out;
  logic                 vblnk_prev;
  logic                 frame_start;
  logic [N-1:0]         hit;
  logic [N-1:0]         opaque;
  logic [SPR_RGB_W-1:0] rgb_mix;

  assign bus_in = vga_in;

  // Reset value 1 keeps a blanking level present at reset release from looking like a new frame.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) vblnk_prev <= 1'b1;
    else      vblnk_prev <= bus_in.vblnk;
  end

  assign frame_start = bus_in.vblnk & ~vblnk_prev;
  assign frame_tick  = frame_start;

  for (genvar k = 0; k < N; k++) begin : g_chan
    sprite_layer_n_sprite_channel #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .ADDR_W  (ADDR_W),
      .ROM_LAT (ROM_LAT)
    ) u_chan (
      .pclk        (pclk),
      .rst         (rst),
      .frame_start (frame_start),
      .xpos        (xpos[SPR_COORD_W*k +: SPR_COORD_W]),
      .ypos        (ypos[SPR_COORD_W*k +: SPR_COORD_W]),
      .en          (spr_en[k]),
      .hcount      (bus_in.hcount),
      .vcount      (bus_in.vcount),
      .hblnk       (bus_in.hblnk),
      .vblnk       (bus_in.vblnk),
      .pixel_addr  (pixel_addr[ADDR_W*k +: ADDR_W]),
      .hit         (hit[k])
    );

    assign opaque[k] = hit[k] & (rom_data[SPR_RGB_W*k +: SPR_RGB_W] != KEY_RGB);
  end

  // Stage 1 plus ROM_LAT stages: lines the bus up with the returning ROM data.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= ROM_LAT; i++) bus_pipe[i] <= '0;
    end else begin
      bus_pipe[0] <= bus_in;
      for (int i = 1; i <= ROM_LAT; i++) bus_pipe[i] <= bus_pipe[i-1];
    end
  end

  assign bus_al = bus_pipe[ROM_LAT];

  // Walk from lowest to highest priority so channel 0 is applied last and wins.
  always_comb begin
    rgb_mix = bus_al.rgb;
    for (int k = N - 1; k >= 0; k--) begin
      if (opaque[k]) rgb_mix = rom_data[SPR_RGB_W*k +: SPR_RGB_W];
    end
  end

  always_comb begin
    bus_mix     = bus_al;
    bus_mix.rgb = rgb_mix;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) bus_out <= '0;
    else      bus_out <= bus_mix;
  end

  assign vga_out = bus_out;

`ifdef SPRITE_COLLISION_EN
  logic [N-1:0] acc;
  logic [N-1:0] collide;

  always_comb begin
    collide = '0;
    for (int k = 0; k < N; k++) begin
      collide[k] = opaque[k] & |(opaque & ~(N'(1) << k));
    end
  end

  // A collision on the frame boundary cycle seeds the new accumulator rather than the reported flags.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      coll_flags <= '0;
    end else if (frame_start) begin
      coll_flags <= acc;
      acc        <= collide;
    end else begin
      acc <= acc | collide;
    end
  end
`else
  assign coll_flags = '0;
`endif

endmodule
